// File: rtl/alu_seq.sv
// alu_seq: handshaked, width-parametrised ALU with registered result and NZCV flags.
// Single-cycle logic/arith/shift ops; MUL runs as an iterative shift-add over WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 64,
  parameter int CNTW  = 7
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] BusW,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SHW = CNTW - 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LSL  = 4'b0011;
  localparam logic [3:0] OP_LSR  = 4'b0100;
  localparam logic [3:0] OP_ASR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t state, next_state;

  logic             accept;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             big_shift;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNTW-1:0]  cnt;

  // Any amount with a bit at or above log2(WIDTH) shifts everything out.
  assign big_shift = |BusB[WIDTH-1:SHW];
  assign shamt     = BusB[SHW-1:0];

  // Subtraction is A + ~B + 1 so the carry out doubles as the no-borrow flag.
  assign add_sum = {1'b0, BusA} + {1'b0, BusB};
  assign sub_sum = {1'b0, BusA} + {1'b0, ~BusB} + {{WIDTH{1'b0}}, 1'b1};

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign accept   = in_valid && in_ready;

  // Single-cycle result and carry/overflow for the currently presented operation.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUCtrl)
      OP_AND:  alu_res = BusA & BusB;
      OP_OR:   alu_res = BusA | BusB;
      OP_XOR:  alu_res = BusA ^ BusB;
      OP_PASS: alu_res = BusB;
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (add_sum[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_c   = sub_sum[WIDTH];
        alu_v   = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (sub_sum[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_LSL:  alu_res = big_shift ? '0 : (BusA << shamt);
      OP_LSR:  alu_res = big_shift ? '0 : (BusA >> shamt);
      OP_ASR:  alu_res = big_shift ? {WIDTH{BusA[WIDTH-1]}}
                                   : WIDTH'($signed(BusA) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // State register; reset parks the controller in IDLE and drops any MUL in progress.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state and handshake outputs; in_ready is masked while reset is asserted.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = resetl;
        if (in_valid && resetl)
          next_state = (ALUCtrl == OP_MUL) ? MUL : DONE;
      end
      MUL: begin
        if (cnt == CNTW'(1)) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Result/flag registers and the shift-add multiplier datapath.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      BusW     <= '0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else if (accept) begin
      if (ALUCtrl == OP_MUL) begin
        mcand  <= BusA;
        mplier <= BusB;
        acc    <= '0;
        cnt    <= CNTW'(WIDTH);
      end else begin
        BusW     <= alu_res;
        Zero     <= (alu_res == '0);
        Negative <= alu_res[WIDTH-1];
        Carry    <= alu_c;
        Overflow <= alu_v;
      end
    end else if (state == MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNTW'(1);
      if (cnt == CNTW'(1)) begin
        BusW     <= acc_next;
        Zero     <= (acc_next == '0);
        Negative <= acc_next[WIDTH-1];
        Carry    <= 1'b0;
        Overflow <= 1'b0;
      end
    end
  end

endmodule
